// File: rtl/activity_pkg.sv
// Shared types and constants for the activity trigger sequencer.
package activity_pkg;

  localparam int DEF_CHANNELS = 16;
  localparam int DEF_SEL_W    = 7;
  localparam int DEF_CNT_W    = 16;

  localparam logic [1:0] MODE_CONT    = 2'd0;
  localparam logic [1:0] MODE_BURST   = 2'd1;
  localparam logic [1:0] MODE_DUTY    = 2'd2;
  localparam logic [1:0] MODE_STAGGER = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/therm_mask.sv
// Count-to-thermometer encoder; counts above g_CHANNELS saturate to all ones.
module therm_mask
  import activity_pkg::*;
#(
  parameter int g_CHANNELS = DEF_CHANNELS,
  parameter int g_SEL_W    = DEF_SEL_W
) (
  input  logic [g_SEL_W-1:0]    count,
  output logic [g_CHANNELS-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < g_CHANNELS; i++) begin
      mask[i] = (int'(count) > i);
    end
  end

endmodule

// File: rtl/activity_sequencer.sv
// Sequences g_CHANNELS activity trigger lines in CONT, BURST, DUTY or STAGGER mode.
//   state   | meaning
//   IDLE    | waiting for a start rising edge with valid config
//   ON      | trig toggles every edge on enabled channels
//   OFF     | DUTY off phase, trig held low
//   DONE    | one-cycle done pulse, then back to IDLE
module activity_sequencer
  import activity_pkg::*;
#(
  parameter int g_CHANNELS = DEF_CHANNELS,
  parameter int g_SEL_W    = DEF_SEL_W,
  parameter int g_CNT_W    = DEF_CNT_W
) (
  input  logic                  clkActivity,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [g_SEL_W-1:0]    numCh,
  input  logic [g_CNT_W-1:0]    burstLen,
  input  logic [g_CNT_W-1:0]    dutyOn,
  input  logic [g_CNT_W-1:0]    dutyOff,
  output logic [g_CHANNELS-1:0] trig,
  output logic [g_CHANNELS-1:0] en,
  output logic                  busy,
  output logic                  done
);

  localparam logic [g_CNT_W-1:0]    CNT_ONE = g_CNT_W'(1);
  localparam logic [g_CHANNELS-1:0] CH_ONE  = g_CHANNELS'(1);

  state_t                state, state_nxt;
  logic                  start_d;
  logic [1:0]            mode_q, mode_nxt;
  logic [g_SEL_W-1:0]    numch_q, numch_nxt;
  logic [g_CNT_W-1:0]    burst_q, burst_nxt;
  logic [g_CNT_W-1:0]    on_q, on_nxt;
  logic [g_CNT_W-1:0]    off_q, off_nxt;
  logic [g_CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [g_CHANNELS-1:0] trig_q, trig_nxt;
  logic [g_CHANNELS-1:0] en_q, en_nxt;
  logic [g_CHANNELS-1:0] mask_live, mask_limit, toggled;
  logic                  start_evt, cfg_ok;

  therm_mask #(.g_CHANNELS(g_CHANNELS), .g_SEL_W(g_SEL_W)) u_mask_live (
    .count (numCh),
    .mask  (mask_live)
  );

  therm_mask #(.g_CHANNELS(g_CHANNELS), .g_SEL_W(g_SEL_W)) u_mask_limit (
    .count (numch_q),
    .mask  (mask_limit)
  );

  assign start_evt = start & ~start_d;
  assign toggled   = ~trig_q & en_q;

  always_comb begin
    cfg_ok = (numCh != '0);
    case (mode)
      MODE_BURST, MODE_STAGGER: if (burstLen == '0) cfg_ok = 1'b0;
      MODE_DUTY:                if (dutyOn == '0) cfg_ok = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    numch_nxt = numch_q;
    burst_nxt = burst_q;
    on_nxt    = on_q;
    off_nxt   = off_q;
    cnt_nxt   = cnt_q;
    trig_nxt  = trig_q;
    en_nxt    = en_q;
    case (state)
      ST_IDLE: begin
        if (start_evt && !stop) begin
          mode_nxt  = mode;
          numch_nxt = numCh;
          burst_nxt = burstLen;
          on_nxt    = dutyOn;
          off_nxt   = dutyOff;
          if (cfg_ok) begin
            state_nxt = ST_ON;
            trig_nxt  = '0;
            en_nxt    = (mode == MODE_STAGGER) ? CH_ONE : mask_live;
            case (mode)
              MODE_BURST:   cnt_nxt = burstLen;
              MODE_DUTY:    cnt_nxt = dutyOn;
              MODE_STAGGER: cnt_nxt = burstLen - CNT_ONE;
              default:      cnt_nxt = '0;
            endcase
          end
        end
      end
      ST_ON: begin
        if (stop) begin
          state_nxt = ST_DONE;
          trig_nxt  = '0;
          en_nxt    = '0;
        end else begin
          case (mode_q)
            MODE_BURST: begin
              if (cnt_q == '0) begin
                state_nxt = ST_DONE;
                trig_nxt  = '0;
                en_nxt    = '0;
              end else begin
                trig_nxt = toggled;
                cnt_nxt  = cnt_q - CNT_ONE;
              end
            end
            MODE_DUTY: begin
              if (cnt_q != '0) begin
                trig_nxt = toggled;
                cnt_nxt  = cnt_q - CNT_ONE;
              end else if (off_q == '0) begin
                trig_nxt = toggled;
                cnt_nxt  = on_q - CNT_ONE;
              end else begin
                // The edge entering OFF is the first of the off-phase edges.
                state_nxt = ST_OFF;
                trig_nxt  = '0;
                cnt_nxt   = off_q - CNT_ONE;
              end
            end
            MODE_STAGGER: begin
              trig_nxt = toggled;
              if (cnt_q == '0) begin
                en_nxt  = ((en_q << 1) | CH_ONE) & mask_limit;
                cnt_nxt = burst_q - CNT_ONE;
              end else begin
                cnt_nxt = cnt_q - CNT_ONE;
              end
            end
            default: trig_nxt = toggled;
          endcase
        end
      end
      ST_OFF: begin
        if (stop) begin
          state_nxt = ST_DONE;
          trig_nxt  = '0;
          en_nxt    = '0;
        end else if (cnt_q == '0) begin
          // Returning edge already counts as the first on-phase toggle.
          state_nxt = ST_ON;
          trig_nxt  = en_q;
          cnt_nxt   = on_q - CNT_ONE;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        trig_nxt  = '0;
        en_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clkActivity) begin
    if (!rstN) begin
      state   <= ST_IDLE;
      start_d <= 1'b0;
      mode_q  <= '0;
      numch_q <= '0;
      burst_q <= '0;
      on_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      trig_q  <= '0;
      en_q    <= '0;
    end else begin
      state   <= state_nxt;
      start_d <= start;
      mode_q  <= mode_nxt;
      numch_q <= numch_nxt;
      burst_q <= burst_nxt;
      on_q    <= on_nxt;
      off_q   <= off_nxt;
      cnt_q   <= cnt_nxt;
      trig_q  <= trig_nxt;
      en_q    <= en_nxt;
    end
  end

  assign trig = trig_q;
  assign en   = en_q;
  assign busy = (state == ST_ON) || (state == ST_OFF);
  assign done = (state == ST_DONE);

endmodule
